ecc_scalar_feeder: RTL

Upstream companion to the ECC point-multiplication controller. Captures the 384-bit secret scalar from the host side as twelve 32-bit words and issues the start command to the controller. During the Montgomery ladder it returns one scalar bit per digit request, MSB first. It zeroizes the scalar when the operation finishes.

---
 rtl/ecc_scalar_feeder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ecc_scalar_feeder.sv
// Feeds the 384-bit ECC scalar to the point-mult controller: loads 12 words MSW-first, issues the command,
// returns one bit per rising digit request 1 cycle later, zeroizes at end; no backpressure, load_en_i is never stalled.
module ecc_scalar_feeder #(
    parameter int REG_SIZE = 384,
    parameter int WORD_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic              load_clr_i,
    input  logic              start_i,
    input  logic [2:0]        cmd_i,
    input  logic              busy_i,
    input  logic              req_digit_i,
    output logic [2:0]        ecc_cmd_o,
    output logic              digit_o,
    output logic              loaded_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int NWORDS = REG_SIZE / WORD_W;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int BCW    = $clog2(REG_SIZE + 1);

    localparam logic [2:0] CMD_KEYGEN = 3'd1;
    localparam logic [2:0] CMD_DOUBLE = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [REG_SIZE-1:0] scalar;
    logic [WCW-1:0]      word_cnt;
    logic [BCW-1:0]      bit_cnt;
    logic                req_q;
    logic                busy_q;

    logic req_rise;
    logic busy_fall;
    logic words_full;
    logic start_ok;

    assign req_rise   = req_digit_i & ~req_q;
    assign busy_fall  = busy_q & ~busy_i;
    assign words_full = (word_cnt == WCW'(NWORDS));
    // Doubling needs no scalar; keygen only once all words are in.
    assign start_ok   = (cmd_i == CMD_DOUBLE) || ((cmd_i == CMD_KEYGEN) && loaded_o);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            scalar    <= '0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            ecc_cmd_o <= 3'd0;
            digit_o   <= 1'b0;
            loaded_o  <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            req_q  <= req_digit_i;
            busy_q <= busy_i;
            done_o <= 1'b0;

            case (state)
                S_IDLE, S_LOAD: begin
                    if (load_clr_i) begin
                        scalar   <= '0;
                        word_cnt <= '0;
                        loaded_o <= 1'b0;
                        err_o    <= 1'b0;
                        state    <= S_IDLE;
                    end else if (load_en_i) begin
                        // A load in the same cycle as start_i wins; the start is dropped.
                        if (words_full) begin
                            err_o <= 1'b1;
                        end else begin
                            scalar   <= {scalar[REG_SIZE-WORD_W-1:0], load_data_i};
                            word_cnt <= word_cnt + 1'b1;
                            loaded_o <= (word_cnt == WCW'(NWORDS - 1));
                            state    <= S_LOAD;
                        end
                    end else if (start_i) begin
                        if (start_ok) begin
                            ecc_cmd_o <= cmd_i;
                            bit_cnt   <= '0;
                            state     <= S_ISSUE;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (load_en_i) begin
                        err_o <= 1'b1;
                    end
                    if (busy_i) begin
                        ecc_cmd_o <= 3'd0;
                        state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (load_en_i) begin
                        err_o <= 1'b1;
                    end
                    // Shifting the MSB out returns the bits MSB first and scrubs the register as it goes.
                    if (req_rise) begin
                        if (bit_cnt == BCW'(REG_SIZE)) begin
                            err_o   <= 1'b1;
                            digit_o <= 1'b0;
                        end else begin
                            digit_o <= scalar[REG_SIZE-1];
                            scalar  <= scalar << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (busy_fall) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (load_en_i) begin
                        err_o <= 1'b1;
                    end
                    done_o   <= 1'b1;
                    scalar   <= '0;
                    word_cnt <= '0;
                    bit_cnt  <= '0;
                    digit_o  <= 1'b0;
                    loaded_o <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
